// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - Requester ports and Dmem bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic              p0_lock;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_we;
    logic              p1_lock;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    // Environment side: both requesters plus the Dmem instance.
    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_rvalid,
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_rvalid,
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - Two-port Dmem arbiter, port 0 priority, port 1 starvation guard; lock FSM when DMEM_ARB_LOCK_EN is defined
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0]  starve_cnt;
    logic              grant0;
    logic              grant1;
    logic              p0_rvalid_q;
    logic              p1_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic [ADDR_W-1:0] mem_address_c;
    logic [DATA_W-1:0] mem_write_data_c;
    logic              mem_read_c;
    logic              mem_write_c;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } lock_state_t;

    lock_state_t lock_state;
`else
    logic unused_lock;
    assign unused_lock = bus.p0_lock | bus.p1_lock;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.p1_req && (starve_cnt == CNT_MAX)) begin
            grant1 = 1'b1;
        end else if (bus.p0_req) begin
            grant0 = 1'b1;
        end else if (bus.p1_req) begin
            grant1 = 1'b1;
        end
`ifdef DMEM_ARB_LOCK_EN
        // The owner is exclusive, overriding the starvation guard as well.
        if (lock_state == OWN0) begin
            grant0 = bus.p0_req;
            grant1 = 1'b0;
        end else if (lock_state == OWN1) begin
            grant0 = 1'b0;
            grant1 = bus.p1_req;
        end
`endif
    end

    always_comb begin
        mem_address_c    = '0;
        mem_write_data_c = '0;
        mem_read_c       = 1'b0;
        mem_write_c      = 1'b0;
        if (grant0) begin
            mem_address_c    = bus.p0_addr;
            mem_write_data_c = bus.p0_wdata;
            mem_write_c      = bus.p0_we;
            mem_read_c       = ~bus.p0_we;
        end else if (grant1) begin
            mem_address_c    = bus.p1_addr;
            mem_write_data_c = bus.p1_wdata;
            mem_write_c      = bus.p1_we;
            mem_read_c       = ~bus.p1_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.p1_req && !grant1) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Dmem reads combinationally, so read data is captured at the edge ending the ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= grant0 & ~bus.p0_we;
            p1_rvalid_q <= grant1 & ~bus.p1_we;
            if (grant0 && !bus.p0_we) begin
                p0_rdata_q <= bus.mem_read_data;
            end
            if (grant1 && !bus.p1_we) begin
                p1_rdata_q <= bus.mem_read_data;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= UNLOCKED;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (grant0 && bus.p0_lock) begin
                        lock_state <= OWN0;
                    end else if (grant1 && bus.p1_lock) begin
                        lock_state <= OWN1;
                    end
                end
                OWN0: begin
                    if (grant0 && !bus.p0_lock) begin
                        lock_state <= UNLOCKED;
                    end
                end
                OWN1: begin
                    if (grant1 && !bus.p1_lock) begin
                        lock_state <= UNLOCKED;
                    end
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end
`endif

    assign bus.p0_ack         = grant0;
    assign bus.p1_ack         = grant1;
    assign bus.p0_rvalid      = p0_rvalid_q;
    assign bus.p1_rvalid      = p1_rvalid_q;
    assign bus.p0_rdata       = p0_rdata_q;
    assign bus.p1_rdata       = p1_rdata_q;
    assign bus.mem_address    = mem_address_c;
    assign bus.mem_write_data = mem_write_data_c;
    assign bus.mem_read       = mem_read_c;
    assign bus.mem_write      = mem_write_c;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - Randomized self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    localparam int WAIT_MAX = 4;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Dmem stand-in: combinational read, write on posedge.
    logic [31:0] dmem [16];
    assign bus.mem_read_data = dmem[bus.mem_address[3:0]];
    always @(posedge clk) begin
        if (bus.mem_write) dmem[bus.mem_address[3:0]] <= bus.mem_write_data;
    end

    int tests_run;
    int tests_failed;

    // Reference model state
    int          p1_wait;
    int          owner;
    logic [31:0] ref_mem [16];
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    logic        g0, g1;

    task automatic set_p0(input logic req, input logic we, input logic lk, input int addr, input logic [31:0] data);
        bus.p0_req = req; bus.p0_we = we; bus.p0_lock = lk; bus.p0_addr = 32'(addr); bus.p0_wdata = data;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic lk, input int addr, input logic [31:0] data);
        bus.p1_req = req; bus.p1_we = we; bus.p1_lock = lk; bus.p1_addr = 32'(addr); bus.p1_wdata = data;
    endtask

    task automatic predict();
        g0 = 1'b0;
        g1 = 1'b0;
        if (owner == 0) g0 = bus.p0_req;
        else if (owner == 1) g1 = bus.p1_req;
        else if (bus.p1_req && p1_wait >= WAIT_MAX) g1 = 1'b1;
        else if (bus.p0_req) g0 = 1'b1;
        else if (bus.p1_req) g1 = 1'b1;
    endtask

    task automatic tick();
        logic rst, rq1, we0, we1, lk0, lk1;
        logic [3:0] a0, a1;
        logic [31:0] d0, d1;
        predict();
        rst = reset; rq1 = bus.p1_req;
        we0 = bus.p0_we; we1 = bus.p1_we; lk0 = bus.p0_lock; lk1 = bus.p1_lock;
        a0 = bus.p0_addr[3:0]; a1 = bus.p1_addr[3:0]; d0 = bus.p0_wdata; d1 = bus.p1_wdata;
        @(posedge clk);
        if (rst) begin
            exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
            p1_wait = 0; owner = -1;
        end else begin
            exp_rv0 = g0 && !we0;
            exp_rv1 = g1 && !we1;
            if (exp_rv0) exp_rd0 = ref_mem[a0];
            if (exp_rv1) exp_rd1 = ref_mem[a1];
            p1_wait = (rq1 && !g1) ? p1_wait + 1 : 0;
`ifdef DMEM_ARB_LOCK_EN
            if (owner < 0) begin
                if (g0 && lk0) owner = 0;
                else if (g1 && lk1) owner = 1;
            end else if (owner == 0 && g0 && !lk0) owner = -1;
            else if (owner == 1 && g1 && !lk1) owner = -1;
`endif
        end
        if (g0 && we0) ref_mem[a0] = d0;
        if (g1 && we1) ref_mem[a1] = d1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_p0(0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (bus.p0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_p0_rvalid got %0b exp 0", bus.p0_rvalid); end
        tests_run++; if (bus.p1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_p1_rvalid got %0b exp 0", bus.p1_rvalid); end
        tests_run++; if (bus.p0_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_p0_rdata got %h exp 0", bus.p0_rdata); end
        tests_run++; if (bus.p1_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_p1_rdata got %h exp 0", bus.p1_rdata); end
        tests_run++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_strobes got rd=%0b wr=%0b exp 0 0", bus.mem_read, bus.mem_write); end
        tests_run++; if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_acks got %0b%0b exp 00", bus.p0_ack, bus.p1_ack); end
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            set_p0(1, 1, 0, i, 32'hA500_0001 + 32'(i) * 32'h0101_0101);
            tick();
        end
        set_p0(0, 0, 0, 0, 0);
    endtask

    task automatic test_write_read();
        set_p0(1, 1, 0, 5, 32'hDEADBEEF);
        #2;
        tests_run++; if (bus.p0_ack !== 1'b1) begin tests_failed++; $display("FAIL wr_ack got %0b exp 1", bus.p0_ack); end
        tests_run++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin tests_failed++; $display("FAIL wr_strobes got wr=%0b rd=%0b exp 1 0", bus.mem_write, bus.mem_read); end
        tests_run++; if (bus.mem_address !== 32'd5 || bus.mem_write_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_bus got %h/%h exp 5/deadbeef", bus.mem_address, bus.mem_write_data); end
        tick();
        set_p0(1, 0, 0, 5, 0);
        #2;
        tests_run++; if (bus.p0_ack !== 1'b1 || bus.mem_read !== 1'b1) begin tests_failed++; $display("FAIL rd_ack got ack=%0b rd=%0b exp 1 1", bus.p0_ack, bus.mem_read); end
        tick();
        set_p0(0, 0, 0, 0, 0);
        tests_run++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_data got v=%0b %h exp 1 deadbeef", bus.p0_rvalid, bus.p0_rdata); end
        tick();
        tests_run++; if (bus.p0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_pulse got %0b exp 0", bus.p0_rvalid); end
    endtask

    task automatic test_collision();
        set_p0(1, 0, 0, 2, 0);
        set_p1(1, 0, 0, 3, 0);
        #2;
        tests_run++; if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin tests_failed++; $display("FAIL coll_first got %0b%0b exp 10", bus.p0_ack, bus.p1_ack); end
        tick();
        set_p0(0, 0, 0, 0, 0);
        #2;
        tests_run++; if (bus.p1_ack !== 1'b1) begin tests_failed++; $display("FAIL coll_second got %0b exp 1", bus.p1_ack); end
        tests_run++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== ref_mem[2]) begin tests_failed++; $display("FAIL coll_p0_data got %h exp %h", bus.p0_rdata, ref_mem[2]); end
        tick();
        set_p1(0, 0, 0, 0, 0);
        tests_run++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== ref_mem[3]) begin tests_failed++; $display("FAIL coll_p1_data got %h exp %h", bus.p1_rdata, ref_mem[3]); end
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] d;
        d = $urandom;
        set_p1(1, 1, 0, 9, d);
        for (int k = 1; k <= WAIT_MAX + 1; k++) begin
            set_p0(1, 0, 0, $urandom_range(0, 15), 0);
            #2;
            if (k <= WAIT_MAX) begin
                tests_run++; if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin tests_failed++; $display("FAIL starve_wait%0d got %0b%0b exp 10", k, bus.p0_ack, bus.p1_ack); end
            end else begin
                tests_run++; if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b1) begin tests_failed++; $display("FAIL starve_grant got %0b%0b exp 01", bus.p0_ack, bus.p1_ack); end
            end
            tick();
        end
        set_p0(0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        tick();
        tests_run++; if (dmem[9] !== d) begin tests_failed++; $display("FAIL starve_mem9 got %h exp %h", dmem[9], d); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_p1(1, 0, 0, i, 0);
            #2;
            tests_run++; if (bus.p1_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack%0d got %0b exp 1", i, bus.p1_ack); end
            tick();
            tests_run++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== ref_mem[i]) begin tests_failed++; $display("FAIL b2b_data%0d got v=%0b %h exp 1 %h", i, bus.p1_rvalid, bus.p1_rdata, ref_mem[i]); end
        end
        set_p1(0, 0, 0, 0, 0);
        tick();
        tests_run++; if (bus.p1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got %0b exp 0", bus.p1_rvalid); end
    endtask

    task automatic test_lock();
        logic p1_done;
        set_p1(1, 1, 1, 4, $urandom);
        #2;
        tests_run++; if (bus.p1_ack !== 1'b1) begin tests_failed++; $display("FAIL lock_take got %0b exp 1", bus.p1_ack); end
        tick();
        p1_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_p0(1, 0, 0, k, 0);
            if (p1_done) set_p1(1, k[0], 1, 8 + k, $urandom);
            #2;
            predict();
`ifdef DMEM_ARB_LOCK_EN
            tests_run++; if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b1) begin tests_failed++; $display("FAIL lock_hold%0d got %0b%0b exp 01", k, bus.p0_ack, bus.p1_ack); end
`else
            if (k == 0) begin
                tests_run++; if (bus.p0_ack !== 1'b1) begin tests_failed++; $display("FAIL nolock_prio got %0b exp 1", bus.p0_ack); end
            end
`endif
            tests_run++; if (bus.p0_ack !== g0 || bus.p1_ack !== g1) begin tests_failed++; $display("FAIL lock_model%0d got %0b%0b exp %0b%0b", k, bus.p0_ack, bus.p1_ack, g0, g1); end
            p1_done = g1;
            tick();
        end
        // p1 releases (or keeps trying until granted) with lock=0
        for (int k = 0; k < 8; k++) begin
            if (p1_done && k > 0) break;
            set_p1(1, 0, 0, 1, 0);
            #2;
            predict();
            tests_run++; if (bus.p0_ack !== g0 || bus.p1_ack !== g1) begin tests_failed++; $display("FAIL lock_rel%0d got %0b%0b exp %0b%0b", k, bus.p0_ack, bus.p1_ack, g0, g1); end
            p1_done = g1;
            tick();
        end
        set_p1(0, 0, 0, 0, 0);
        #2;
        tests_run++; if (bus.p0_ack !== 1'b1) begin tests_failed++; $display("FAIL lock_after got %0b exp 1", bus.p0_ack); end
        tick();
        set_p0(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_p0(1, 0, 0, 7, 0);
        tick();
        set_p0(0, 0, 0, 0, 0);
        tests_run++; if (bus.p0_rdata !== ref_mem[7]) begin tests_failed++; $display("FAIL rst_pre got %h exp %h", bus.p0_rdata, ref_mem[7]); end
        set_p0(1, 0, 0, 3, 0);
        reset = 1'b1;
        #2;
        tests_run++; if (bus.p0_ack !== 1'b1) begin tests_failed++; $display("FAIL rst_ack got %0b exp 1", bus.p0_ack); end
        tick();
        reset = 1'b0;
        set_p0(0, 0, 0, 0, 0);
        tests_run++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_clear got v=%0b %h exp 0 0", bus.p0_rvalid, bus.p0_rdata); end
        tick();
        set_p0(1, 0, 0, 3, 0);
        tick();
        set_p0(0, 0, 0, 0, 0);
        tests_run++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== ref_mem[3]) begin tests_failed++; $display("FAIL rst_fresh got v=%0b %h exp 1 %h", bus.p0_rvalid, bus.p0_rdata, ref_mem[3]); end
        tick();
    endtask

    task automatic test_random();
        logic pend0, pend1;
        logic [31:0] e_addr, e_wd;
        logic e_rd, e_wr;
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!pend0) set_p0(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0, $urandom_range(0, 15), $urandom);
            if (!pend1) set_p1(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0, $urandom_range(0, 15), $urandom);
            #2;
            predict();
            e_addr = '0; e_wd = '0; e_rd = 1'b0; e_wr = 1'b0;
            if (g0) begin e_addr = bus.p0_addr; e_wd = bus.p0_wdata; e_wr = bus.p0_we; e_rd = !bus.p0_we; end
            if (g1) begin e_addr = bus.p1_addr; e_wd = bus.p1_wdata; e_wr = bus.p1_we; e_rd = !bus.p1_we; end
            tests_run++; if (bus.p0_ack !== g0 || bus.p1_ack !== g1) begin tests_failed++; $display("FAIL rnd_ack n=%0d got %0b%0b exp %0b%0b", n, bus.p0_ack, bus.p1_ack, g0, g1); end
            tests_run++; if (bus.mem_read !== e_rd || bus.mem_write !== e_wr) begin tests_failed++; $display("FAIL rnd_strobe n=%0d got %0b%0b exp %0b%0b", n, bus.mem_read, bus.mem_write, e_rd, e_wr); end
            tests_run++; if (bus.mem_address !== e_addr || bus.mem_write_data !== e_wd) begin tests_failed++; $display("FAIL rnd_bus n=%0d got %h/%h exp %h/%h", n, bus.mem_address, bus.mem_write_data, e_addr, e_wd); end
            pend0 = bus.p0_req && !g0;
            pend1 = bus.p1_req && !g1;
            tick();
            tests_run++; if (bus.p0_rvalid !== exp_rv0 || (exp_rv0 && bus.p0_rdata !== exp_rd0)) begin tests_failed++; $display("FAIL rnd_p0_rd n=%0d got %0b %h exp %0b %h", n, bus.p0_rvalid, bus.p0_rdata, exp_rv0, exp_rd0); end
            tests_run++; if (bus.p1_rvalid !== exp_rv1 || (exp_rv1 && bus.p1_rdata !== exp_rd1)) begin tests_failed++; $display("FAIL rnd_p1_rd n=%0d got %0b %h exp %0b %h", n, bus.p1_rvalid, bus.p1_rdata, exp_rv1, exp_rd1); end
        end
        set_p0(0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        p1_wait = 0;
        owner = -1;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
        g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        do_reset();
        test_reset();
        preload();
        test_write_read();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_lock();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
